// File: rtl/ysyx_23060025_pkg.sv
// Shared definitions for the ysyx_23060025 load/store stage.
// Holds the LSU state encoding, the load/store width codes and the bus response code.
package ysyx_23060025_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_AR   = 3'd1,
        LSU_R    = 3'd2,
        LSU_AW_W = 3'd3,
        LSU_B    = 3'd4,
        LSU_RESP = 3'd5
    } lsu_state_e;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// Byte-lane steering for the LSU: store data shift and strobes, load lane extract and extend,
// and the misalignment check. Purely combinational.
module ysyx_23060025_lsu_align
    import ysyx_23060025_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wstrb,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt    = {addr_lo, 3'b000};
    assign rshift   = rdata >> shamt;
    assign wdata_sh = wdata_in << shamt;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wstrb    = 4'b1111;
        load_val = rshift;
        misalign = 1'b0;
        case (funct3)
            LS_B: begin
                wstrb    = 4'b0001 << addr_lo;
                load_val = {{24{rshift[7]}}, rshift[7:0]};
            end
            LS_BU: begin
                wstrb    = 4'b0001 << addr_lo;
                load_val = {24'd0, rshift[7:0]};
            end
            LS_H: begin
                wstrb    = 4'b0011 << addr_lo;
                load_val = {{16{rshift[15]}}, rshift[15:0]};
                misalign = addr_lo[0];
            end
            LS_HU: begin
                wstrb    = 4'b0011 << addr_lo;
                load_val = {16'd0, rshift[15:0]};
                misalign = addr_lo[0];
            end
            LS_W: begin
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_lsu_stage.sv
// Load/store stage between EXU and WBU: one op in flight on a single-outstanding
// AXI4-Lite-style data bus, with load alignment/extension and non-memory forwarding.
module ysyx_23060025_lsu_stage
    import ysyx_23060025_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_ld,
    input  logic            in_is_st,
    input  logic [2:0]      in_funct3,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_wdata,
    input  logic [DW-1:0]   in_res,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [DW-1:0]   out_data,
    output logic            out_err,
    output logic [AW-1:0]   araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [DW-1:0]   rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [AW-1:0]   awaddr,
    output logic            awvalid,
    input  logic            awready,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wstrb,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    lsu_state_e state, state_nxt;
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;
    logic       aw_done, w_done;

    logic [2:0]    sel_funct3;
    logic [1:0]    sel_addr_lo;
    logic [DW-1:0] wdata_sh, load_val;
    logic [3:0]    wstrb_sh;
    logic          misalign;

    // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
    assign sel_funct3  = (state == LSU_IDLE) ? in_funct3     : funct3_q;
    assign sel_addr_lo = (state == LSU_IDLE) ? in_addr[1:0] : addr_lo_q;

    ysyx_23060025_lsu_align u_align (
        .funct3   (sel_funct3),
        .addr_lo  (sel_addr_lo),
        .wdata_in (in_wdata),
        .rdata    (rdata),
        .wdata_sh (wdata_sh),
        .wstrb    (wstrb_sh),
        .load_val (load_val),
        .misalign (misalign)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        out_valid = 1'b0;
        case (state)
            LSU_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if ((in_is_ld || in_is_st) && misalign) state_nxt = LSU_RESP;
                    else if (in_is_ld)                      state_nxt = LSU_AR;
                    else if (in_is_st)                      state_nxt = LSU_AW_W;
                    else                                    state_nxt = LSU_RESP;
                end
            end
            LSU_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = LSU_R;
            end
            LSU_R: begin
                rready = 1'b1;
                if (rvalid) state_nxt = LSU_RESP;
            end
            LSU_AW_W: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = LSU_B;
            end
            LSU_B: begin
                bready = 1'b1;
                if (bvalid) state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LSU_IDLE;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            araddr    <= '0;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LSU_IDLE: if (in_valid) begin
                    funct3_q  <= in_funct3;
                    addr_lo_q <= in_addr[1:0];
                    out_rd    <= in_rd;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    out_err   <= 1'b0;
                    out_data  <= '0;
                    if ((in_is_ld || in_is_st) && misalign) begin
                        out_err <= 1'b1;
                    end else if (in_is_ld) begin
                        araddr <= {in_addr[AW-1:2], 2'b00};
                    end else if (in_is_st) begin
                        awaddr <= {in_addr[AW-1:2], 2'b00};
                        wdata  <= wdata_sh;
                        wstrb  <= wstrb_sh;
                    end else begin
                        out_data <= in_res;
                    end
                end
                LSU_R: if (rvalid) begin
                    out_data <= load_val;
                    out_err  <= (rresp != RESP_OKAY);
                end
                LSU_AW_W: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                end
                LSU_B: if (bvalid) out_err <= (bresp != RESP_OKAY);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_lsu_stage.sv
// Self-checking bench for ysyx_23060025_lsu_stage: directed scenarios plus randomized ops
// driven through a scripted bus responder and compared against a byte-level reference model.
module tb_ysyx_23060025_lsu_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_is_ld, in_is_st;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_res;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_err;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] res;
        logic [31:0] rdv;
        logic [4:0]  rd;
        logic [1:0]  rsp;
        int          ar_d, r_d, aw_d, w_d, b_d, o_d;
    } op_t;

    ysyx_23060025_lsu_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_ld(in_is_ld), .in_is_st(in_is_st),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_res(in_res), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: works on byte sizes and offsets, not on the RTL's decode.
    task automatic model(input op_t op, output bit mis, output logic [31:0] data,
                         output bit err, output logic [31:0] wexp, output logic [3:0] sexp);
        int          off, size;
        logic [31:0] v;
        off  = int'(op.addr % 4);
        size = (op.f3[1:0] == 2'd0) ? 1 : (op.f3[1:0] == 2'd1) ? 2 : 4;
        mis  = (op.ld || op.st) && ((op.addr % size) != 0);
        wexp = op.wd << (8 * off);
        sexp = 4'(((1 << size) - 1) << off);
        data = 32'd0;
        err  = 1'b0;
        if (mis) begin
            err = 1'b1;
        end else if (op.ld) begin
            v = op.rdv >> (8 * off);
            if (size == 1) begin
                v = v & 32'h0000_00FF;
                if (!op.f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'h0000_FFFF;
                if (!op.f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            data = v;
            err  = (op.rsp != 2'b00);
        end else if (op.st) begin
            err = (op.rsp != 2'b00);
        end else begin
            data = op.res;
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_is_ld = 0; in_is_st = 0; in_funct3 = 0;
        in_addr = 0; in_wdata = 0; in_res = 0; in_rd = 0; out_ready = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    function automatic op_t blank_op();
        op_t o;
        o.ld = 0; o.st = 0; o.f3 = 3'b010; o.addr = 0; o.wd = 0; o.res = 0; o.rdv = 0;
        o.rd = 5'd1; o.rsp = 2'b00;
        o.ar_d = 0; o.r_d = 0; o.aw_d = 0; o.w_d = 0; o.b_d = 0; o.o_d = 0;
        return o;
    endfunction

    // Runs one op end to end, playing the bus slave with the op's delays and
    // checking every cycle against the model. All loops are bounded by the op's own delays.
    task automatic run_op(input op_t op, input string tag);
        bit          mis, err_e, aw_d_f, w_d_f;
        logic [31:0] data_e, wexp;
        logic [3:0]  sexp;
        int          c;
        model(op, mis, data_e, err_e, wexp, sexp);

        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready_idle got=%b want=1", tag, in_ready);
        end
        in_valid = 1; in_is_ld = op.ld; in_is_st = op.st; in_funct3 = op.f3;
        in_addr = op.addr; in_wdata = op.wd; in_res = op.res; in_rd = op.rd;
        tick();
        in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_res = $urandom;
        in_rd = 5'($urandom); in_funct3 = 3'($urandom);

        if (!mis && op.ld) begin
            for (int i = 0; i <= op.ar_d; i++) begin
                total++;
                if ({arvalid, araddr, awvalid, out_valid, in_ready} !== {1'b1, op.addr[31:2], 2'b00, 3'b000}) begin
                    bad++;
                    $display("FAIL %s ar_phase cyc=%0d got arvalid=%b araddr=%h aw=%b ov=%b ir=%b want arvalid=1 araddr=%h",
                             tag, i, arvalid, araddr, awvalid, out_valid, in_ready, {op.addr[31:2], 2'b00});
                end
                arready = (i == op.ar_d);
                tick();
                arready = 0;
            end
            for (int i = 0; i <= op.r_d; i++) begin
                total++;
                if ({rready, arvalid, out_valid} !== 3'b100) begin
                    bad++; $display("FAIL %s r_phase cyc=%0d got rready/arvalid/out_valid=%b want 100",
                                    tag, i, {rready, arvalid, out_valid});
                end
                rvalid = (i == op.r_d);
                rdata  = (i == op.r_d) ? op.rdv : $urandom;
                rresp  = (i == op.r_d) ? op.rsp : 2'($urandom);
                tick();
                rvalid = 0; rdata = $urandom;
            end
        end else if (!mis && op.st) begin
            aw_d_f = 0; w_d_f = 0; c = 0;
            while (!(aw_d_f && w_d_f) && c < 20) begin
                total++;
                if ({awvalid, wvalid, arvalid, out_valid, wdata, wstrb, awaddr[31:2]} !==
                    {!aw_d_f, !w_d_f, 2'b00, wexp, sexp, op.addr[31:2]}) begin
                    bad++;
                    $display("FAIL %s aw_w_phase cyc=%0d got awv=%b wv=%b arv=%b ov=%b wdata=%h wstrb=%b want awv=%b wv=%b wdata=%h wstrb=%b",
                             tag, c, awvalid, wvalid, arvalid, out_valid, wdata, wstrb, !aw_d_f, !w_d_f, wexp, sexp);
                end
                awready = (c == op.aw_d);
                wready  = (c == op.w_d);
                tick();
                if (c == op.aw_d) aw_d_f = 1;
                if (c == op.w_d)  w_d_f  = 1;
                awready = 0; wready = 0;
                c++;
            end
            for (int i = 0; i <= op.b_d; i++) begin
                total++;
                if ({bready, awvalid, wvalid, out_valid} !== 4'b1000) begin
                    bad++; $display("FAIL %s b_phase cyc=%0d got bready/awv/wv/ov=%b want 1000",
                                    tag, i, {bready, awvalid, wvalid, out_valid});
                end
                bvalid = (i == op.b_d);
                bresp  = (i == op.b_d) ? op.rsp : 2'($urandom);
                tick();
                bvalid = 0;
            end
        end

        for (int i = 0; i <= op.o_d; i++) begin
            total++;
            if ({out_valid, out_rd, out_data, out_err, in_ready, arvalid, awvalid, wvalid} !==
                {1'b1, op.rd, data_e, err_e, 4'b0000}) begin
                bad++;
                $display("FAIL %s resp cyc=%0d got ov=%b rd=%0d data=%h err=%b ir=%b arv=%b awv=%b wv=%b want ov=1 rd=%0d data=%h err=%b",
                         tag, i, out_valid, out_rd, out_data, out_err, in_ready, arvalid, awvalid, wvalid, op.rd, data_e, err_e);
            end
            out_ready = (i == op.o_d);
            tick();
            out_ready = 0;
        end
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL %s back_to_idle got in_ready/out_valid=%b want 10", tag, {in_ready, out_valid});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        total++;
        if ({in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, out_rd, out_data, out_err, araddr, awaddr, wdata, wstrb}
            !== {1'b1, 6'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_state got ir=%b ov=%b arv=%b rr=%b awv=%b wv=%b br=%b rd=%0d data=%h err=%b araddr=%h awaddr=%h wdata=%h wstrb=%b want ir=1 rest 0",
                     in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, out_rd, out_data, out_err, araddr, awaddr, wdata, wstrb);
        end
    endtask

    task automatic test_load_basic();
        op_t o = blank_op();
        o.ld = 1; o.f3 = 3'b000; o.addr = 32'h8000_0003; o.rdv = 32'h80FF_0000; o.rd = 5'd7;
        run_op(o, "lb_sign");
        o = blank_op();
        o.ld = 1; o.f3 = 3'b101; o.addr = 32'h8000_0002; o.rdv = 32'h8001_0000; o.rd = 5'd9;
        run_op(o, "lhu_zero");
    endtask

    task automatic test_store_basic();
        op_t o = blank_op();
        o.st = 1; o.f3 = 3'b001; o.addr = 32'h8000_0002; o.wd = 32'h0000_ABCD; o.rd = 5'd3;
        run_op(o, "sh_lane2");
    endtask

    task automatic test_store_skew();
        op_t o = blank_op();
        o.st = 1; o.f3 = 3'b010; o.addr = 32'h8000_0010; o.wd = 32'hDEAD_BEEF; o.rd = 5'd0;
        o.aw_d = 3; o.w_d = 0;
        run_op(o, "sw_aw_late");
        o.aw_d = 0; o.w_d = 2; o.f3 = 3'b000; o.addr = 32'h8000_0011;
        run_op(o, "sb_w_late");
    endtask

    task automatic test_misaligned();
        op_t o = blank_op();
        o.ld = 1; o.f3 = 3'b010; o.addr = 32'h8000_0001; o.rd = 5'd5;
        run_op(o, "lw_misaligned");
        o = blank_op();
        o.st = 1; o.f3 = 3'b001; o.addr = 32'h8000_0003; o.wd = 32'h1234; o.rd = 5'd6;
        run_op(o, "sh_misaligned");
    endtask

    task automatic test_nonmem_stall();
        op_t o = blank_op();
        o.res = 32'h1234_5678; o.rd = 5'd12; o.o_d = 4;
        run_op(o, "alu_stall");
    endtask

    task automatic test_bus_error();
        op_t o = blank_op();
        o.ld = 1; o.f3 = 3'b010; o.addr = 32'h8000_0020; o.rdv = 32'hCAFE_F00D; o.rsp = 2'b10;
        run_op(o, "lw_slverr");
        o = blank_op();
        o.st = 1; o.f3 = 3'b010; o.addr = 32'h8000_0024; o.rsp = 2'b11;
        run_op(o, "sw_decerr");
    endtask

    task automatic test_reset_in_r();
        in_valid = 1; in_is_ld = 1; in_is_st = 0; in_funct3 = 3'b010;
        in_addr = 32'h8000_0040; in_rd = 5'd4;
        tick();
        in_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        total++;
        if (rready !== 1'b1) begin
            bad++; $display("FAIL reset_in_r reached_r got rready=%b want 1", rready);
        end
        reset = 1;
        tick();
        reset = 0;
        total++;
        if ({in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, araddr, out_data, out_err}
            !== {1'b1, 6'b0, 32'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_in_r after got ir=%b ov=%b arv=%b rr=%b awv=%b wv=%b br=%b araddr=%h data=%h err=%b want ir=1 rest 0",
                     in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready, araddr, out_data, out_err);
        end
    endtask

    task automatic test_random();
        logic [2:0] codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 60; n++) begin
            op_t o = blank_op();
            int  k = $urandom_range(2);
            o.ld   = (k == 0);
            o.st   = (k == 1) && (codes[0] == 3'b000);
            if (o.st) o.f3 = codes[$urandom_range(2)];
            else      o.f3 = codes[$urandom_range(4)];
            o.addr = $urandom;
            if ($urandom_range(3) != 0) begin
                if (o.f3[1:0] == 2'd2)      o.addr[1:0] = 2'b00;
                else if (o.f3[1:0] == 2'd1) o.addr[0]   = 1'b0;
            end
            o.wd   = $urandom;
            o.res  = $urandom;
            o.rdv  = $urandom;
            o.rd   = 5'($urandom);
            o.rsp  = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            o.ar_d = $urandom_range(2); o.r_d = $urandom_range(2);
            o.aw_d = $urandom_range(3); o.w_d = $urandom_range(3);
            o.b_d  = $urandom_range(2); o.o_d = $urandom_range(2);
            run_op(o, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_basic();
        test_store_skew();
        test_misaligned();
        test_nonmem_stall();
        test_bus_error();
        test_reset_in_r();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
